// File: rtl/sound_event_queue.sv
// rtl/sound_event_queue.sv - event FIFO feeding paced play_start/clip_sel pulses to the playback block
// Optional build macro SND_COALESCE_EN: a move landing on a move already at the FIFO tail is merged.
module sound_event_queue #(
  parameter int DEPTH       = 4,
  parameter int GAP_CYCLES  = 50000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   ev_move,
  input  logic                   ev_wall,
  input  logic                   ev_goal,
  input  logic                   playback_busy,
  output logic                   play_start,
  output logic [1:0]             clip_sel,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [7:0]             drop_cnt,
  output logic                   timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] CLIP_MOVE = 2'd0;
  localparam logic [1:0] CLIP_WALL = 2'd1;
  localparam logic [1:0] CLIP_GOAL = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_PLAYING,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_drop_cnt;
  logic          r_play_start;
  logic [1:0]    r_clip_sel;
  logic          r_timeout_err;
  logic [GW-1:0] r_gap_cnt;
  logic [TW-1:0] r_ack_cnt;

  logic          w_any_lo;
  logic          w_prio_drop;
  logic          w_coalesce;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_full_drop;
  logic          w_drop;
  logic          w_wr_en;
  logic [1:0]    w_wr_code;
  logic          w_ack_expire;
  logic          w_load_gap;

`ifdef SND_COALESCE_EN
  logic [AW-1:0] w_tail_idx;
  logic [1:0]    w_tail_code;

  always_comb begin
    w_tail_idx  = r_wr_ptr - AW'(1);
    w_tail_code = r_mem[w_tail_idx];
    w_coalesce  = ev_move & ~ev_wall & ~ev_goal & (r_count != '0) & (w_tail_code == CLIP_MOVE);
  end
`else
  always_comb begin
    w_coalesce = 1'b0;
  end
`endif

  // Only the highest-priority event of a cycle is a write candidate; a goal always wins and flushes.
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_any_lo    = ev_move | ev_wall;
    w_prio_drop = (ev_goal & w_any_lo) | (ev_wall & ev_move);
    w_push      = ~ev_goal & w_any_lo & ~w_coalesce & (~w_full | w_pop);
    w_full_drop = ~ev_goal & w_any_lo & ~w_coalesce & w_full & ~w_pop;
    w_drop      = w_prio_drop | w_full_drop;
    w_wr_en     = ev_goal | w_push;
    w_wr_code   = ev_goal ? CLIP_GOAL : (ev_wall ? CLIP_WALL : CLIP_MOVE);
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_ack_expire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && (r_gap_cnt == '0) && !playback_busy) begin
          w_pop        = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (playback_busy) begin
          w_next_state = S_PLAYING;
        end else if (r_ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
          w_ack_expire = 1'b1;
          w_next_state = S_GAP;
        end
      end
      S_PLAYING: begin
        if (!playback_busy) begin
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    w_load_gap = (w_next_state == S_GAP) && (r_state != S_GAP);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_code;
    end
  end

  // A goal turns the queue into just itself; a head popped in the same cycle is still issued.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (ev_goal) begin
      r_rd_ptr <= r_wr_ptr;
      r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count  <= CW'(1);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_play_start  <= 1'b0;
      r_clip_sel    <= CLIP_MOVE;
      r_timeout_err <= 1'b0;
      r_ack_cnt     <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_play_start <= w_pop;
      if (w_pop) begin
        r_clip_sel <= r_mem[r_rd_ptr];
      end
      if (w_ack_expire) begin
        r_timeout_err <= 1'b1;
      end
      if (r_state == S_WAIT_ACK) begin
        r_ack_cnt <= r_ack_cnt + TW'(1);
      end else begin
        r_ack_cnt <= '0;
      end
      if (w_load_gap) begin
        r_gap_cnt <= GW'(GAP_CYCLES);
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GW'(1);
      end
    end
  end

  assign play_start  = r_play_start;
  assign clip_sel    = r_clip_sel;
  assign q_count     = r_count;
  assign drop_cnt    = r_drop_cnt;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sound_event_queue.sv
// tb/tb_sound_event_queue.sv - directed and randomized bench for sound_event_queue against a timeline model
`timescale 1ns/1ps
module tb_sound_event_queue;

  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int ACK   = 16;
`ifdef SND_COALESCE_EN
  localparam int MOVES3_Q = 1;
`else
  localparam int MOVES3_Q = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ev_move = 1'b0;
  logic       ev_wall = 1'b0;
  logic       ev_goal = 1'b0;
  logic       busy = 1'b0;
  logic       play_start;
  logic [1:0] clip_sel;
  logic [2:0] q_count;
  logic [7:0] drop_cnt;
  logic       timeout_err;

  sound_event_queue #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(GAP),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .ev_move(ev_move),
    .ev_wall(ev_wall),
    .ev_goal(ev_goal),
    .playback_busy(busy),
    .play_start(play_start),
    .clip_sel(clip_sel),
    .q_count(q_count),
    .drop_cnt(drop_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: pending clip codes plus timestamps of the playback handshake.
  int mq[$];
  int m_drops;
  bit m_terr;
  bit m_play;
  int m_clip;
  bit m_wait;
  bit m_playing;
  int m_issue;
  int m_free_at;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drops   = 0;
    m_terr    = 0;
    m_play    = 0;
    m_clip    = 0;
    m_wait    = 0;
    m_playing = 0;
    m_issue   = 0;
    m_free_at = 0;
  endtask

  // Advance the model by the current cycle's inputs; afterwards m_* describe the next cycle.
  task automatic model_advance();
    bit pop;
    bit drop;
    bit coal;
    int pre_n;
    int tail;
    int code;
    pop  = 0;
    drop = 0;
    coal = 0;
    if (reset) begin
      model_reset();
      return;
    end
    pre_n = mq.size();
    tail  = (pre_n > 0) ? mq[pre_n-1] : -1;
    if (m_wait && (cyc > m_issue)) begin
      if (busy) begin
        m_wait    = 0;
        m_playing = 1;
      end else if (cyc == m_issue + ACK) begin
        m_wait    = 0;
        m_terr    = 1;
        m_free_at = cyc + 2 + GAP;
      end
    end else if (m_playing) begin
      if (!busy) begin
        m_playing = 0;
        m_free_at = cyc + 2 + GAP;
      end
    end else if (!m_wait && (cyc >= m_free_at) && (pre_n > 0) && !busy) begin
      pop = 1;
    end
    m_play = pop;
    if (pop) begin
      m_clip  = mq.pop_front();
      m_wait  = 1;
      m_issue = cyc + 1;
    end
    if (ev_goal) begin
      mq.delete();
      mq.push_back(2);
      if (ev_wall || ev_move) drop = 1;
    end else if (ev_wall || ev_move) begin
      if (ev_wall && ev_move) drop = 1;
      code = ev_wall ? 1 : 0;
`ifdef SND_COALESCE_EN
      coal = ev_move && !ev_wall && (pre_n > 0) && (tail == 0);
`endif
      if (!coal) begin
        if ((pre_n == DEPTH) && !pop) drop = 1;
        else mq.push_back(code);
      end
    end
    if (drop && (m_drops < 255)) m_drops++;
  endtask

  task automatic step();
    @(negedge clk);
    chk("play_start", 32'(play_start), int'(m_play));
    chk("clip_sel", 32'(clip_sel), m_clip);
    chk("q_count", 32'(q_count), mq.size());
    chk("drop_cnt", 32'(drop_cnt), m_drops);
    chk("timeout_err", 32'(timeout_err), int'(m_terr));
    model_advance();
    cyc++;
    @(posedge clk);
    #1;
    ev_move = 0;
    ev_wall = 0;
    ev_goal = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic wait_play(input string name, input int bound, output int n);
    n = 0;
    while ((play_start !== 1'b1) && (n < bound)) begin
      step();
      n++;
    end
    chk(name, 32'(play_start), 1);
  endtask

  task automatic settle(input int n);
    busy = 0;
    repeat (n) step();
  endtask

  int n;
  int issues;
  int pb_wait;
  int pb_left;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    step();
    chk("rst_play_start", 32'(play_start), 0);
    chk("rst_clip_sel", 32'(clip_sel), 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    reset = 0;

    // 1: latency t+2, then gap after busy falls
    ev_move = 1;
    step();
    chk("t1_q_after_enq", 32'(q_count), 1);
    step();
    chk("t1_play_t2", 32'(play_start), 1);
    chk("t1_clip_move", 32'(clip_sel), 0);
    busy = 1;
    ev_move = 1;
    step();
    repeat (9) step();
    busy = 0;
    wait_play("t1_second_issue", 100, n);
    chk("t1_gap_respected", 32'(n > GAP), 1);
    chk("t1_second_clip", 32'(clip_sel), 0);
    busy = 1;
    repeat (3) step();
    settle(15);

    // 2: simultaneous move+wall
    do_reset();
    busy = 1;
    ev_move = 1;
    ev_wall = 1;
    step();
    chk("t2_q_one", 32'(q_count), 1);
    chk("t2_drop_one", 32'(drop_cnt), 1);
    busy = 0;
    wait_play("t2_issue", 20, n);
    chk("t2_clip_wall", 32'(clip_sel), 1);
    busy = 1;
    repeat (2) step();
    settle(15);

    // 3: overflow while busy, then drain four issues
    do_reset();
    busy = 1;
    repeat (5) begin
      ev_wall = 1;
      step();
    end
    chk("t3_q_full", 32'(q_count), 4);
    chk("t3_drop_one", 32'(drop_cnt), 1);
    busy = 0;
    issues = 0;
    repeat (4) begin
      wait_play("t3_issue", 100, n);
      if (play_start === 1'b1) issues++;
      busy = 1;
      repeat (3) step();
      busy = 0;
    end
    chk("t3_issue_count", 32'(issues), 4);
    settle(15);
    chk("t3_q_empty", 32'(q_count), 0);

    // 4: goal flush while a clip plays
    do_reset();
    ev_move = 1;
    step();
    wait_play("t4_first", 10, n);
    busy = 1;
    repeat (3) begin
      ev_move = 1;
      step();
    end
    chk("t4_q_moves", 32'(q_count), MOVES3_Q);
    ev_goal = 1;
    step();
    chk("t4_q_goal", 32'(q_count), 1);
    chk("t4_no_drop", 32'(drop_cnt), 0);
    busy = 0;
    wait_play("t4_goal_issue", 100, n);
    chk("t4_clip_goal", 32'(clip_sel), 2);
    chk("t4_gap_respected", 32'(n > GAP), 1);
    busy = 1;
    repeat (2) step();
    settle(15);

    // 5: ack timeout
    do_reset();
    ev_wall = 1;
    step();
    wait_play("t5_issue", 10, n);
    repeat (ACK) step();
    chk("t5_terr_early", 32'(timeout_err), 0);
    step();
    chk("t5_terr_set", 32'(timeout_err), 1);
    ev_move = 1;
    step();
    wait_play("t5_reissue", 100, n);
    busy = 1;
    repeat (2) step();
    settle(15);
    chk("t5_terr_sticky", 32'(timeout_err), 1);

    // 6: repeated moves while busy, then reset mid-PLAYING
    do_reset();
    ev_move = 1;
    step();
    wait_play("t6_issue", 10, n);
    busy = 1;
    repeat (3) begin
      ev_move = 1;
      step();
    end
    chk("t6_q_moves", 32'(q_count), MOVES3_Q);
    chk("t6_no_drop", 32'(drop_cnt), 0);
    reset = 1;
    step();
    reset = 0;
    chk("t6_rst_play_start", 32'(play_start), 0);
    chk("t6_rst_clip_sel", 32'(clip_sel), 0);
    chk("t6_rst_q_count", 32'(q_count), 0);
    chk("t6_rst_drop_cnt", 32'(drop_cnt), 0);
    chk("t6_rst_timeout_err", 32'(timeout_err), 0);
    repeat (5) step();
    settle(5);

    // drop counter saturation
    do_reset();
    busy = 1;
    repeat (264) begin
      ev_wall = 1;
      step();
    end
    chk("sat_drop_cnt", 32'(drop_cnt), 255);
    chk("sat_q_full", 32'(q_count), 4);
    settle(5);

    // randomized traffic with an emulated playback block
    do_reset();
    pb_wait = 0;
    pb_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_play) begin
        if ($urandom_range(0, 7) != 0) begin
          pb_wait = $urandom_range(1, 3);
          pb_left = $urandom_range(1, 12);
        end
      end
      if (pb_wait > 0) begin
        pb_wait--;
        busy = 0;
      end else if (pb_left > 0) begin
        pb_left--;
        busy = 1;
      end else begin
        busy = ($urandom_range(0, 63) == 0);
      end
      ev_move = ($urandom_range(0, 4) == 0);
      ev_wall = ($urandom_range(0, 6) == 0);
      ev_goal = ($urandom_range(0, 40) == 0);
      reset   = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 0;
    settle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
